// File: rtl/a4092_pkg.sv
// Shared types and constants for the A4092 Zorro III slave front end.
package a4092_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ACTIVE = 3'd2,
    DONE   = 3'd3,
    MISS   = 3'd4
  } z3_state_e;

  localparam logic [7:0] AUTOCFG_BASE = 8'hFF;

  localparam int N_REGION  = 3;
  localparam int ROM       = 0;
  localparam int SCSI      = 1;
  localparam int ACFG      = 2;
  // addr_q holds A[31:8], so A23 (the 8 MB split) sits at bit 15
  localparam int SPLIT_BIT = 15;

  function automatic logic sel_dtack(input logic [N_REGION-1:0] region,
                                     input logic [N_REGION-1:0] dtacks);
    return |(region & dtacks);
  endfunction

endpackage

// File: rtl/z3_addr_match.sv
// Combinational region hit vector for a latched Zorro III address.
module z3_addr_match #(
  parameter logic [7:0] AUTOCFG_BASE = a4092_pkg::AUTOCFG_BASE
) (
  input  logic [23:0] addr_q,
  input  logic [7:0]  base_addr,
  input  logic        configured,
  input  logic        shutup,
  output logic [2:0]  hit_s
);
  import a4092_pkg::*;

  logic base_match_s;

  // One-hot by construction: configured selects autoconfig vs base, SPLIT_BIT selects ROM vs SCSI
  always_comb begin
    hit_s        = 3'b000;
    base_match_s = 1'b0;
    if (!shutup) begin
      base_match_s = configured && (addr_q[23:16] == base_addr);
      hit_s[ACFG]  = !configured && (addr_q[23:16] == AUTOCFG_BASE);
      hit_s[ROM]   = base_match_s && !addr_q[SPLIT_BIT];
      hit_s[SCSI]  = base_match_s && addr_q[SPLIT_BIT];
    end else begin
      hit_s        = 3'b000;
    end
  end

endmodule

// File: rtl/z3_slave_decode.sv
// Zorro III slave-cycle front end: address latch, region decode, dtack merge with timeout.
module z3_slave_decode #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          TMO_W          = 7,
  parameter logic [7:0]  AUTOCFG_BASE   = a4092_pkg::AUTOCFG_BASE
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        FCS_n,
  input  logic [23:0] ADDR,
  input  logic        READ,
  input  logic        configured,
  input  logic [7:0]  base_addr,
  input  logic        shutup,
  input  logic        rom_dtack,
  input  logic        scsi_dtack,
  input  logic        autocfg_dtack,
  output logic        rom_region,
  output logic        scsi_region,
  output logic        autocfg_region,
  output logic        slave_cycle,
  output logic        read_q,
  output logic        bus_dtack,
  output logic        timeout
);
  import a4092_pkg::*;

  z3_state_e            state_r, state_nx;
  logic [23:0]          addr_r, addr_nx;
  logic                 read_lat_r, read_lat_nx;
  logic                 read_q_r, read_q_nx;
  logic [N_REGION-1:0]  region_r, region_nx;
  logic                 slave_r, slave_nx;
  logic                 dtack_r, dtack_nx;
  logic                 tmo_r, tmo_nx;
  logic [TMO_W-1:0]     cnt_r, cnt_nx;
  logic [N_REGION-1:0]  hit_s;
  logic [N_REGION-1:0]  dtack_vec_s;

  assign dtack_vec_s = {autocfg_dtack, scsi_dtack, rom_dtack};

  z3_addr_match #(.AUTOCFG_BASE(AUTOCFG_BASE)) u_match (
    .addr_q     (addr_r),
    .base_addr  (base_addr),
    .configured (configured),
    .shutup     (shutup),
    .hit_s      (hit_s)
  );

  // Next-state and next-output logic; every exit to IDLE drops all bus-visible outputs
  always_comb begin
    state_nx    = state_r;
    addr_nx     = addr_r;
    read_lat_nx = read_lat_r;
    read_q_nx   = read_q_r;
    region_nx   = region_r;
    slave_nx    = slave_r;
    dtack_nx    = dtack_r;
    tmo_nx      = 1'b0;
    cnt_nx      = cnt_r;
    case (state_r)
      IDLE: begin
        if (!FCS_n) begin
          addr_nx     = ADDR;
          read_lat_nx = READ;
          state_nx    = DECODE;
        end else begin
          state_nx    = IDLE;
        end
      end
      DECODE: begin
        if (FCS_n) begin
          state_nx = IDLE;
        end else if (|hit_s) begin
          region_nx = hit_s;
          slave_nx  = 1'b1;
          read_q_nx = read_lat_r;
          cnt_nx    = '0;
          state_nx  = ACTIVE;
        end else begin
          state_nx  = MISS;
        end
      end
      ACTIVE: begin
        if (FCS_n) begin
          region_nx = '0;
          slave_nx  = 1'b0;
          read_q_nx = 1'b0;
          state_nx  = IDLE;
        end else if (sel_dtack(region_r, dtack_vec_s)) begin
          dtack_nx  = 1'b1;
          state_nx  = DONE;
        end else if (cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          dtack_nx  = 1'b1;
          tmo_nx    = 1'b1;
          state_nx  = DONE;
        end else begin
          cnt_nx    = cnt_r + TMO_W'(1);
        end
      end
      DONE: begin
        if (FCS_n) begin
          region_nx = '0;
          slave_nx  = 1'b0;
          read_q_nx = 1'b0;
          dtack_nx  = 1'b0;
          state_nx  = IDLE;
        end else begin
          state_nx  = DONE;
        end
      end
      MISS: begin
        if (FCS_n) begin
          state_nx = IDLE;
        end else begin
          state_nx = MISS;
        end
      end
      default: begin
        region_nx = '0;
        slave_nx  = 1'b0;
        read_q_nx = 1'b0;
        dtack_nx  = 1'b0;
        cnt_nx    = '0;
        state_nx  = IDLE;
      end
    endcase
  end

  // State, latches, counter and registered outputs
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r    <= IDLE;
      addr_r     <= 24'h000000;
      read_lat_r <= 1'b0;
      read_q_r   <= 1'b0;
      region_r   <= '0;
      slave_r    <= 1'b0;
      dtack_r    <= 1'b0;
      tmo_r      <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_nx;
      addr_r     <= addr_nx;
      read_lat_r <= read_lat_nx;
      read_q_r   <= read_q_nx;
      region_r   <= region_nx;
      slave_r    <= slave_nx;
      dtack_r    <= dtack_nx;
      tmo_r      <= tmo_nx;
      cnt_r      <= cnt_nx;
    end
  end

  assign rom_region     = region_r[ROM];
  assign scsi_region    = region_r[SCSI];
  assign autocfg_region = region_r[ACFG];
  assign slave_cycle    = slave_r;
  assign read_q         = read_q_r;
  assign bus_dtack      = dtack_r;
  assign timeout        = tmo_r;

endmodule

// File: tb/tb_z3_slave_decode.sv
// Directed self-checking bench for z3_slave_decode.
module tb_z3_slave_decode;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        FCS_n;
  logic [23:0] ADDR;
  logic        READ;
  logic        configured;
  logic [7:0]  base_addr;
  logic        shutup;
  logic        rom_dtack, scsi_dtack, autocfg_dtack;
  logic        rom_region, scsi_region, autocfg_region;
  logic        slave_cycle, read_q, bus_dtack, timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Output bundle order: {rom, scsi, acfg, slave, read_q, dtack, timeout}
  logic [6:0] outs;
  assign outs = {rom_region, scsi_region, autocfg_region, slave_cycle, read_q, bus_dtack, timeout};

  localparam logic [6:0] O_ZERO     = 7'b0000000;
  localparam logic [6:0] O_ROM_RD   = 7'b1001100;
  localparam logic [6:0] O_ROM_ACK  = 7'b1001110;
  localparam logic [6:0] O_ROM_TMO  = 7'b1001111;
  localparam logic [6:0] O_SCSI_WR  = 7'b0101000;
  localparam logic [6:0] O_SCSI_ACK = 7'b0101010;
  localparam logic [6:0] O_ACFG_RD  = 7'b0011100;
  localparam logic [6:0] O_ACFG_ACK = 7'b0011110;

  z3_slave_decode #(.TIMEOUT_CYCLES(64), .TMO_W(7), .AUTOCFG_BASE(8'hFF)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .ADDR(ADDR), .READ(READ),
    .configured(configured), .base_addr(base_addr), .shutup(shutup),
    .rom_dtack(rom_dtack), .scsi_dtack(scsi_dtack), .autocfg_dtack(autocfg_dtack),
    .rom_region(rom_region), .scsi_region(scsi_region), .autocfg_region(autocfg_region),
    .slave_cycle(slave_cycle), .read_q(read_q), .bus_dtack(bus_dtack), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    RESET_n = 1'b0; FCS_n = 1'b1; ADDR = 24'h000000; READ = 1'b0;
    configured = 1'b0; base_addr = 8'h00; shutup = 1'b0;
    rom_dtack = 1'b0; scsi_dtack = 1'b0; autocfg_dtack = 1'b0;
    tick(); tick();
    chk("reset", outs, O_ZERO);
    RESET_n = 1'b1;
    tick();
    chk("post_reset_idle", outs, O_ZERO);

    // 1: ROM read, dtack driven after edge 4
    configured = 1'b1; base_addr = 8'h40; ADDR = 24'h401234; READ = 1'b1; FCS_n = 1'b0;
    tick(); chk("t1_e1", outs, O_ZERO);
    tick(); chk("t1_e2", outs, O_ROM_RD);
    tick(); tick(); chk("t1_e4", outs, O_ROM_RD);
    rom_dtack = 1'b1;
    tick(); chk("t1_e5_ack", outs, O_ROM_ACK);
    rom_dtack = 1'b0;
    tick(); chk("t1_done_hold", outs, O_ROM_ACK);
    FCS_n = 1'b1;
    tick(); chk("t1_release", outs, O_ZERO);
    tick();

    // 2: SCSI write, stray rom_dtack ignored
    ADDR = 24'h408010; READ = 1'b0; FCS_n = 1'b0;
    tick(); tick(); chk("t2_e2", outs, O_SCSI_WR);
    rom_dtack = 1'b1;
    tick(); chk("t2_rom_dtack_ignored", outs, O_SCSI_WR);
    rom_dtack = 1'b0;
    tick();
    scsi_dtack = 1'b1;
    tick(); chk("t2_ack", outs, O_SCSI_ACK);
    scsi_dtack = 1'b0; FCS_n = 1'b1;
    tick(); chk("t2_release", outs, O_ZERO);
    tick();

    // 3a: autoconfig hit while unconfigured
    configured = 1'b0; ADDR = 24'hFF0044; READ = 1'b1; FCS_n = 1'b0;
    tick(); tick(); chk("t3_acfg", outs, O_ACFG_RD);
    autocfg_dtack = 1'b1;
    tick(); chk("t3_acfg_ack", outs, O_ACFG_ACK);
    autocfg_dtack = 1'b0; FCS_n = 1'b1;
    tick(); chk("t3_acfg_release", outs, O_ZERO);
    tick();

    // 3b: same address once configured -> miss, never acks
    configured = 1'b1; base_addr = 8'h40; FCS_n = 1'b0;
    autocfg_dtack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("t3_miss", outs, O_ZERO);
    end
    autocfg_dtack = 1'b0; FCS_n = 1'b1;
    tick(); chk("t3_miss_release", outs, O_ZERO);
    tick();

    // 4: timeout at exactly 64 clocks after entering ACTIVE
    ADDR = 24'h401234; READ = 1'b1; FCS_n = 1'b0;
    tick(); tick(); chk("t4_active", outs, O_ROM_RD);
    for (int i = 1; i < 64; i++) begin
      tick(); chk("t4_wait", outs, O_ROM_RD);
    end
    tick(); chk("t4_timeout", outs, O_ROM_TMO);
    tick(); chk("t4_pulse_end", outs, O_ROM_ACK);
    FCS_n = 1'b1;
    tick(); chk("t4_release", outs, O_ZERO);
    tick();

    // dtack on the terminal-count edge wins over timeout
    FCS_n = 1'b0;
    tick(); tick();
    for (int i = 1; i < 64; i++) tick();
    chk("tie_pre", outs, O_ROM_RD);
    rom_dtack = 1'b1;
    tick(); chk("tie_dtack_wins", outs, O_ROM_ACK);
    rom_dtack = 1'b0;
    tick(); chk("tie_no_late_tmo", outs, O_ROM_ACK);
    FCS_n = 1'b1;
    tick(); tick();

    // FCS_n rise beats dtack on the same edge
    FCS_n = 1'b0;
    tick(); tick(); chk("abort_dt_active", outs, O_ROM_RD);
    FCS_n = 1'b1; rom_dtack = 1'b1;
    tick(); chk("abort_beats_dtack", outs, O_ZERO);
    rom_dtack = 1'b0;
    tick(); chk("abort_dt_idle", outs, O_ZERO);

    // 5a: shutup suppresses decode
    shutup = 1'b1; ADDR = 24'h400000; FCS_n = 1'b0;
    rom_dtack = 1'b1;
    tick(); tick(); chk("t5_shutup_e2", outs, O_ZERO);
    tick(); chk("t5_shutup_e3", outs, O_ZERO);
    rom_dtack = 1'b0; FCS_n = 1'b1;
    tick(); shutup = 1'b0;
    tick();

    // 5b: abort two clocks into ACTIVE, shutup raised mid-cycle must not disturb strobes
    FCS_n = 1'b0;
    tick(); tick(); chk("t5_abort_active", outs, O_ROM_RD);
    shutup = 1'b1; configured = 1'b0;
    tick(); chk("t5_stable_strobes", outs, O_ROM_RD);
    tick();
    FCS_n = 1'b1; shutup = 1'b0; configured = 1'b1;
    tick(); chk("t5_abort_clear", outs, O_ZERO);
    tick(); chk("t5_abort_idle", outs, O_ZERO);

    // 6: async reset in DONE, then rerun scenario 1
    FCS_n = 1'b0; READ = 1'b1; ADDR = 24'h401234;
    tick(); tick();
    rom_dtack = 1'b1;
    tick(); chk("t6_done", outs, O_ROM_ACK);
    rom_dtack = 1'b0;
    #1 RESET_n = 1'b0;
    #1 chk("t6_async_reset", outs, O_ZERO);
    FCS_n = 1'b1;
    tick(); RESET_n = 1'b1;
    tick();
    FCS_n = 1'b0;
    tick(); chk("t6_rerun_e1", outs, O_ZERO);
    tick(); chk("t6_rerun_e2", outs, O_ROM_RD);
    tick(); tick();
    rom_dtack = 1'b1;
    tick(); chk("t6_rerun_ack", outs, O_ROM_ACK);
    rom_dtack = 1'b0; FCS_n = 1'b1;
    tick(); chk("t6_rerun_release", outs, O_ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
